sr_pulse_driver: RTL

SR_PULSE_DRIVER -- requirements
Module: sr_pulse_driver

---
 rtl/sr_drv_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 22 ++
 rtl/sr_pulse_driver.sv | 127 ++++++++++++
 3 files changed

// File: rtl/sr_drv_pkg.sv
// Shared types and constants for the S/R latch pulse driver.
// Holds the FSM encoding, counter width and minimum guard lengths.
package sr_drv_pkg;

  localparam int CNT_W = 8;
  localparam int MIN_GAP_CHK = 3;
  localparam int MIN_GAP_NOCHK = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // A phase of w cycles counts down from w-1 to 0.
  function automatic logic [CNT_W-1:0] cnt_load(input int w);
    return CNT_W'(w - 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Synchronous active-high reset clears both stages to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sr_pulse_driver.sv
// Pulse driver for an external S/R latch: IDLE -> PULSE -> GAP.
// Define SR_PULSE_DRIVER_CHECK_EN to enable synchronized Q readback checking.
module sr_pulse_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  input  logic cmd_set,
  output logic cmd_ready,
  output logic S,
  output logic R,
  input  logic Q_in,
  input  logic Q_bar_in,
  output logic exp_q,
  output logic done,
  output logic err
);

`ifdef SR_PULSE_DRIVER_CHECK_EN
  localparam int MIN_GAP = MIN_GAP_CHK;
`else
  localparam int MIN_GAP = MIN_GAP_NOCHK;
`endif

  if (PULSE_W < 1 || PULSE_W > 255) begin : g_bad_pulse
    $error("sr_pulse_driver: PULSE_W out of range");
  end

  if (GAP_W < MIN_GAP || GAP_W > 255) begin : g_bad_gap
    $error("sr_pulse_driver: GAP_W out of range");
  end

  localparam logic [CNT_W-1:0] PULSE_LD = cnt_load(PULSE_W);
  localparam logic [CNT_W-1:0] GAP_LD   = cnt_load(GAP_W);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             cmd_lat;
  logic             chk_fail;

`ifdef SR_PULSE_DRIVER_CHECK_EN
  logic q_s;
  logic qb_s;

  sync_2ff u_sync_q (
    .clk (clk),
    .rst (rst),
    .d   (Q_in),
    .q   (q_s)
  );

  sync_2ff u_sync_qb (
    .clk (clk),
    .rst (rst),
    .d   (Q_bar_in),
    .q   (qb_s)
  );

  // Wrong value or both rails equal (latch not settled / shorted).
  assign chk_fail = (q_s != cmd_lat) || (q_s == qb_s);
`else
  logic unused_q;
  assign unused_q = Q_in ^ Q_bar_in;
  assign chk_fail = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd_lat   <= 1'b0;
      cmd_ready <= 1'b1;
      S         <= 1'b0;
      R         <= 1'b0;
      exp_q     <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state     <= PULSE;
            cmd_lat   <= cmd_set;
            cmd_ready <= 1'b0;
            S         <= cmd_set;
            R         <= !cmd_set;
            cnt       <= PULSE_LD;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            state <= GAP;
            S     <= 1'b0;
            R     <= 1'b0;
            cnt   <= GAP_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            done      <= 1'b1;
            exp_q     <= cmd_lat;
            if (chk_fail) err <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          S         <= 1'b0;
          R         <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule
